// File: rtl/display_scan_if.sv
// Digit-data and display-drive bundle for display_scan.
// The master drives the load strobe and digit bytes; the slave drives the display and the status pulses.
interface display_scan_if;
    logic       load;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] in3;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
    logic       frame_done;

    modport master (
        output load, in0, in1, in2, in3,
        input  an, seg, dp, ack, frame_done
    );

    modport slave (
        input  load, in0, in1, in2, in3,
        output an, seg, dp, ack, frame_done
    );
endinterface

// File: rtl/display_scan.sv
// Multiplexed 4-digit seven-segment scanner with shadow/live double buffering and anode dead-time.
// Optional macro DISP_LEAD_ZERO_BLANK_EN blanks leading zero digits 3..1.
//
//   state    | meaning
//   ST_BLANK | cnt < DEAD: all anodes off, segments and dp off
//   ST_ON    | cnt >= DEAD: anode idx driven, segments decode live[idx]
module display_scan #(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 500
) (
    input logic          clkm,
    input logic          rst_n,
    display_scan_if.slave bus
);
    typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} slot_e;

    localparam logic [15:0] CNT_LAST  = 16'(PRESCALE - 1);
    localparam logic [15:0] DEAD_LAST = 16'(DEAD - 1);

    // Each digit entry is {dp, nibble}.
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    slot_e           state_q, state_d;
    logic [3:0][4:0] shadow_q, shadow_d;
    logic [3:0][4:0] live_q, live_d;
    logic            pend_q, pend_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            ack_q, ack_d;
    logic            fd_q, fd_d;

    logic            slot_end;
    logic            frame_end;
    logic [3:0]      lz_blank;
    logic [4:0]      cur;
    logic            lit;

    // Bits [6:4] of each digit byte carry no meaning for the display.
    logic unused_bits;
    assign unused_bits = ^{bus.in0[6:4], bus.in1[6:4], bus.in2[6:4], bus.in3[6:4]};

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);

`ifdef DISP_LEAD_ZERO_BLANK_EN
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (live_q[3][3:0] == 4'd0) && !live_q[3][4];
        lz_blank[2] = (live_q[3][3:0] == 4'd0) && (live_q[2][3:0] == 4'd0) && !live_q[2][4];
        lz_blank[1] = (live_q[3][3:0] == 4'd0) && (live_q[2][3:0] == 4'd0)
                      && (live_q[1][3:0] == 4'd0) && !live_q[1][4];
    end
`else
    assign lz_blank = 4'b0000;
`endif

    always_comb begin
        cnt_d    = slot_end ? 16'd0 : cnt_q + 16'd1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        state_d  = state_q;
        if (slot_end)
            state_d = ST_BLANK;
        else if (cnt_q == DEAD_LAST)
            state_d = ST_ON;

        shadow_d = shadow_q;
        live_d   = live_q;
        pend_d   = pend_q;
        // Commit reads the pre-edge shadow, so a coincident load lands for the next frame.
        if (frame_end && pend_q) begin
            live_d = shadow_q;
            pend_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d = {bus.in3[7], bus.in3[3:0], bus.in2[7], bus.in2[3:0],
                        bus.in1[7], bus.in1[3:0], bus.in0[7], bus.in0[3:0]};
            pend_d   = 1'b1;
        end

        cur   = live_q[idx_q];
        lit   = (state_q == ST_ON) && !lz_blank[idx_q];
        an_d  = (state_q == ST_ON) ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d = lit ? seg_decode(cur[3:0]) : 7'b1111111;
        dp_d  = lit ? ~cur[4] : 1'b1;
        ack_d = frame_end && pend_q;
        fd_d  = frame_end;
    end

    always_ff @(posedge clkm) begin
        if (!rst_n) begin
            cnt_q    <= 16'd0;
            idx_q    <= 2'd0;
            state_q  <= ST_BLANK;
            shadow_q <= '0;
            live_q   <= '0;
            pend_q   <= 1'b0;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
            ack_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            ack_q    <= ack_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.ack        = ack_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan at PRESCALE=8, DEAD=2: stimulus queues expected digits and
// ack values; a monitor pops them as each digit lights and at each frame_done pulse.
module tb_display_scan;
    typedef struct packed {
        logic [3:0] an;
        logic       dp;
        logic [6:0] seg;
    } disp_t;

    localparam logic [3:0][7:0] V_ZERO = '0;
    localparam logic [3:0][7:0] V_COM  = {8'h01, 8'h06, 8'h06, 8'h80};
    localparam logic [3:0][7:0] V_A    = {8'h02, 8'h03, 8'h04, 8'h05};
    localparam logic [3:0][7:0] V_B    = {8'h07, 8'h08, 8'h09, 8'h85};
    localparam logic [3:0][7:0] V_C    = {8'h03, 8'h02, 8'h01, 8'h00};
    localparam logic [3:0][7:0] V_D    = {8'h0C, 8'h04, 8'h8C, 8'h79};
    localparam logic [3:0][7:0] V_E    = {8'h05, 8'h05, 8'h05, 8'h05};
    localparam logic [3:0][7:0] V_LZ   = {8'h00, 8'h00, 8'h04, 8'h02};

    logic clkm = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    disp_t disp_q[$];
    bit    ack_q[$];

    display_scan_if bus();

    display_scan #(.PRESCALE(8), .DEAD(2)) dut (
        .clkm (clkm),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clkm = ~clkm;
    always @(posedge clkm) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic disp_t exp_entry(input logic [3:0][7:0] by, input int i);
        disp_t e;
        logic  blank;
        blank = 1'b0;
`ifdef DISP_LEAD_ZERO_BLANK_EN
        if (i > 0) begin
            blank = !by[i][7];
            for (int j = i; j < 4; j++)
                if (by[j][3:0] != 4'd0) blank = 1'b0;
        end
`endif
        e.an    = 4'b1111;
        e.an[i] = 1'b0;
        e.seg   = blank ? 7'b1111111 : dec(by[i][3:0]);
        e.dp    = blank ? 1'b1 : ~by[i][7];
        return e;
    endfunction

    task automatic push_frame(input logic [3:0][7:0] by, input int first, input int last);
        for (int i = first; i <= last; i++) disp_q.push_back(exp_entry(by, i));
    endtask

    task automatic tick();
        @(negedge clkm);
    endtask

    task automatic do_load(input logic [3:0][7:0] by);
        bus.in3  = by[3];
        bus.in2  = by[2];
        bus.in1  = by[1];
        bus.in0  = by[0];
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.frame_done !== 1'b1 && n < 40);
        if (bus.frame_done !== 1'b1) fail_now("wait frame_done");
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.an !== pat && n < 40);
        if (bus.an !== pat) fail_now("wait anode");
    endtask

    // Monitor: compare each newly lit digit and the ack value at each frame boundary.
    initial begin
        logic [3:0] prev_an;
        disp_t      e;
        bit         ea;
        prev_an = 4'b1111;
        forever begin
            @(negedge clkm);
            if (rst_n === 1'b1 && bus.an !== prev_an && bus.an !== 4'b1111 && disp_q.size() > 0) begin
                e = disp_q.pop_front();
                chk("digit an", 32'(bus.an), 32'(e.an));
                chk("digit seg", 32'(bus.seg), 32'(e.seg));
                chk("digit dp", 32'(bus.dp), 32'(e.dp));
            end
            if (bus.frame_done === 1'b1) begin
                if (ack_q.size() > 0) begin
                    ea = ack_q.pop_front();
                    chk("ack at boundary", 32'(bus.ack), 32'(ea));
                end else if (bus.ack !== 1'b0) begin
                    chk("unexpected ack", 32'(bus.ack), 32'd0);
                end
            end else if (bus.ack === 1'b1) begin
                chk("ack without frame_done", 32'(bus.ack), 32'd0);
            end
            prev_an = bus.an;
        end
    end

    initial begin
        int c0;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.in0  = 8'h00;
        bus.in1  = 8'h00;
        bus.in2  = 8'h00;
        bus.in3  = 8'h00;

        // Reset and release: digit 0 lights on the third cycle.
        repeat (3) begin
            tick();
            chk("reset an", 32'(bus.an), 32'hF);
            chk("reset ack", 32'(bus.ack), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("post-reset c1 an", 32'(bus.an), 32'hF);
        tick();
        chk("post-reset c2 an", 32'(bus.an), 32'hF);
        tick();
        chk("post-reset c3 an", 32'(bus.an), 32'hE);
        chk("post-reset c3 seg", 32'(bus.seg), 32'b1000000);
        chk("post-reset c3 ack", 32'(bus.ack), 32'd0);

        // Commit at the digit-3 slot end.
        tick();
        tick();
        do_load(V_COM);
        push_frame(V_ZERO, 1, 3);
        ack_q.push_back(1'b1);
        wait_frame();
        push_frame(V_COM, 0, 3);
        ack_q.push_back(1'b0);
        tick();
        chk("ack single cycle", 32'(bus.ack), 32'd0);
        chk("frame_done single cycle", 32'(bus.frame_done), 32'd0);
        wait_frame();

        // Back-to-back loads: only the last one is ever shown.
        push_frame(V_COM, 0, 3);
        ack_q.push_back(1'b1);
        tick();
        do_load(V_A);
        tick();
        do_load(V_B);
        wait_frame();
        push_frame(V_B, 0, 3);
        ack_q.push_back(1'b0);
        wait_frame();

        // Collision: load on the commit edge while C is pending.
        push_frame(V_B, 0, 3);
        ack_q.push_back(1'b1);
        tick();
        do_load(V_C);
        wait_an(4'b0111);
        repeat (4) tick();
        do_load(V_D);
        chk("collision frame_done", 32'(bus.frame_done), 32'd1);
        c0 = cyc;
        push_frame(V_C, 0, 3);
        ack_q.push_back(1'b1);
        wait_frame();
        chk("collision ack spacing", 32'(cyc - c0), 32'd32);
        chk("second collision ack", 32'(bus.ack), 32'd1);
        push_frame(V_D, 0, 3);
        ack_q.push_back(1'b0);
        wait_frame();

        // Mid-frame reset during digit 2 with a load pending.
        push_frame(V_D, 0, 1);
        tick();
        do_load(V_E);
        wait_an(4'b1011);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid reset an", 32'(bus.an), 32'hF);
        chk("mid reset ack", 32'(bus.ack), 32'd0);
        push_frame(V_ZERO, 0, 3);
        ack_q.push_back(1'b0);
        wait_frame();

        // Leading-zero handling.
        push_frame(V_ZERO, 0, 3);
        ack_q.push_back(1'b1);
        tick();
        do_load(V_LZ);
        wait_frame();
        push_frame(V_LZ, 0, 3);
        ack_q.push_back(1'b0);
        wait_frame();
        tick();
        tick();

        chk("display queue drained", 32'(disp_q.size()), 32'd0);
        chk("ack queue drained", 32'(ack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
